word_unstacker: RTL and testbench
=================================

// Module: word_unstacker
//
// PURPOSE
//   Splits one 128-bit block into a stream of four 32-bit words, most significant word first.
//   This is the inverse of the word stacker, whose first-received word fills [127:96].
//   Sits between the AES core's 128-bit result and the 32-bit streamer sink,
//   so that stack -> core -> unstack reproduces the original word order.
//
// PARAMETERS
//   WORD_W   32   width of one output word
//   N_WORDS  4    words per block; block width = WORD_W*N_WORDS (128 by default)
//
// PORTS
//   clk_i     in   1                 clock
//   rst_ni    in   1                 async reset, active low
//   clr_i     in   1                 sync clear, returns block to IDLE
//   enable_i  in   1                 block enable; low = freeze
//   valid_i   in   1                 input block valid
//   ready_o   out  1                 block can accept word_i
//   word_i    in   WORD_W*N_WORDS    input block
//   valid_o   out  1                 output word valid
//   ready_i   in   1                 downstream accepts word_o
//   word_o    out  WORD_W            current output word
//   last_o    out  1                 word_o is the final word of the block
//
// BEHAVIOUR
//   - Clock and reset: one clock, clk_i; rst_ni is asynchronous, active low.
//   - Reset, async, rst_ni=0:
//       state=IDLE, cnt=0, buffer='0.
//       Outputs: valid_o=0, word_o=0, last_o=0; ready_o=enable_i.
//   - clr_i=1: synchronous, same effect as reset.
//       Priority is rst_ni > clr_i > enable_i.
//       A clear mid-block discards the remaining words with no handshake.
//   - Output gating: with enable_i=0, state, cnt and buffer hold.
//       ready_o and valid_o are forced 0, so no transfer completes on either side.
//       word_o and last_o keep showing the held buffer slice.
//   - FSM states, IDLE and SEND:
//       IDLE: ready_o=enable_i, valid_o=0.
//         valid_i & ready_o -> latch word_i into buffer, cnt=0, go to SEND.
//       SEND: valid_o=enable_i.
//         word_o = buffer[WORD_W*(N_WORDS-cnt)-1 -: WORD_W].
//         last_o = (cnt==N_WORDS-1).
//         valid_o & ready_i & ~last_o -> cnt++.
//         valid_o & ready_i & last_o -> cnt=0, buffer='0, go to IDLE.
//   - Latency and stall rules:
//       First word is valid one cycle after the input handshake.
//       A full block takes N_WORDS output handshakes.
//       With ready_i held low, word_o is stable and valid_o stays high.
//   - Input side rules:
//       valid_i is ignored whenever ready_o=0; word_i is sampled only on the handshake.
//   - Widths and counter:
//       cnt is $clog2(N_WORDS) bits, with a minimum of 1 bit.
//       cnt never exceeds N_WORDS-1, so no wrap beyond N_WORDS-1 is legal.
//       When N_WORDS is not a power of two, cnt must still return to 0 after the last word.
//
// CONFIGURATION
//   - Macro: UNSTACKER_PREFETCH_EN
//   - Defined:
//       In SEND, ready_o = enable_i & last_o & ready_i.
//       A new block handshaking in the same cycle as the last word is latched.
//       In that case cnt=0 and the FSM stays in SEND, giving zero bubble between blocks.
//       ready_o then depends combinationally on ready_i.
//   - Undefined:
//       ready_o=0 throughout SEND.
//       Back-to-back blocks cost one IDLE cycle (N_WORDS+1 cycles per block).
//       No combinational path from ready_i to ready_o.
//
// TESTING
//   1. Single block, ready_i=1, word_i=128'h00112233_44556677_8899AABB_CCDDEEFF
//      -> words 00112233, 44556677, 8899AABB, CCDDEEFF on 4 consecutive cycles.
//      -> last_o=1 only on CCDDEEFF; then valid_o=0 and ready_o=1.
//   2. Backpressure: ready_i toggles 1,0,0,1,...
//      -> word_o and valid_o are stable while ready_i=0.
//      -> No word is lost or duplicated; 4 handshakes total.
//   3. Back-to-back blocks A then B, ready_i=1, valid_i=1 continuously
//      -> with PREFETCH_EN: B's first word on the cycle after A's last word (8 cycles total).
//      -> without it: one idle cycle between A's last word and B's first word (9 cycles).
//   4. clr_i=1 after the 2nd word of a block
//      -> next cycle valid_o=0, ready_o=1, word_o=0.
//      -> A new block then starts from its MSW.
//   5. enable_i=0 for 3 cycles during SEND with cnt=1
//      -> valid_o=0, ready_o=0 for those cycles, word_o held.
//      -> Output resumes at word 2 after enable_i=1.
//   6. rst_ni asserted asynchronously mid-cycle during SEND
//      -> valid_o=0 and last_o=0 immediately, without waiting for a clock edge.
//      -> After release the block is IDLE with ready_o=enable_i.

Source files
------------

// File: rtl/word_unstacker_if.sv
// Handshake bundle for word_unstacker: a wide block comes in and narrow words go out.
// The slave modport is the unstacker's view. The master modport is the driver/sink
// side, such as a testbench or the surrounding datapath.
interface word_unstacker_if #(
    parameter int WORD_W  = 32,
    parameter int N_WORDS = 4
);
    // Block side (upstream, e.g. AES core result)
    logic                        valid_i;
    logic                        ready_o;
    logic [WORD_W*N_WORDS-1:0]   word_i;
    // Word side (downstream, e.g. streamer sink)
    logic                        valid_o;
    logic                        ready_i;
    logic [WORD_W-1:0]           word_o;
    logic                        last_o;

    modport slave (
        input  valid_i, word_i, ready_i,
        output ready_o, valid_o, word_o, last_o
    );

    modport master (
        output valid_i, word_i, ready_i,
        input  ready_o, valid_o, word_o, last_o
    );
endinterface

// File: rtl/word_unstacker.sv
// word_unstacker: splits one WORD_W*N_WORDS block into N_WORDS words.
// The most significant word is sent first, so the order matches the word stacker.
// Optional feature macro: UNSTACKER_PREFETCH_EN. When it is defined, the next block
// can be accepted on the same cycle as the last word, so there is no gap between blocks.
module word_unstacker #(
    parameter int WORD_W  = 32,
    parameter int N_WORDS = 4
) (
    input  logic            clk_i,
    input  logic            rst_ni,
    input  logic            clr_i,
    input  logic            enable_i,
    word_unstacker_if.slave bus
);
    localparam int CW = (N_WORDS > 1) ? $clog2(N_WORDS) : 1;
    localparam logic [CW-1:0] LAST_CNT = CW'(N_WORDS - 1);

    typedef enum logic {IDLE = 1'b0, SEND = 1'b1} state_t;

    state_t                    state_reg;
    logic [CW-1:0]             cnt_reg;
    logic [WORD_W*N_WORDS-1:0] buffer_reg;

    logic              is_last;
    logic [WORD_W-1:0] word_arr [N_WORDS];

    // Word slots: slot 0 is the MSW, slot N_WORDS-1 the LSW.
    for (genvar gi = 0; gi < N_WORDS; gi++) begin : g_slice
        assign word_arr[gi] = buffer_reg[WORD_W*(N_WORDS-gi)-1 -: WORD_W];
    end

    assign is_last     = (state_reg == SEND) && (cnt_reg == LAST_CNT);
    assign bus.word_o  = word_arr[cnt_reg];
    assign bus.last_o  = is_last;
    assign bus.valid_o = enable_i && (state_reg == SEND);

`ifdef UNSTACKER_PREFETCH_EN
    // Accept the next block alongside the final word handshake; this ties ready_o to ready_i.
    assign bus.ready_o = enable_i && ((state_reg == IDLE) || (is_last && bus.ready_i));
`else
    // Only accept in IDLE, which keeps ready_i off the ready_o path.
    assign bus.ready_o = enable_i && (state_reg == IDLE);
`endif

    // Control FSM with word counter and block buffer; a low enable freezes everything.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_reg  <= IDLE;
            cnt_reg    <= '0;
            buffer_reg <= '0;
        end else if (clr_i) begin
            state_reg  <= IDLE;
            cnt_reg    <= '0;
            buffer_reg <= '0;
        end else if (enable_i) begin
            case (state_reg)
                IDLE: begin
                    if (bus.valid_i) begin
                        buffer_reg <= bus.word_i;
                        cnt_reg    <= '0;
                        state_reg  <= SEND;
                    end
                end
                SEND: begin
                    if (bus.ready_i) begin
                        if (!is_last) begin
                            cnt_reg <= cnt_reg + CW'(1);
                        end else begin
                            cnt_reg <= '0;
`ifdef UNSTACKER_PREFETCH_EN
                            if (bus.valid_i) begin
                                buffer_reg <= bus.word_i;
                                state_reg  <= SEND;
                            end else begin
                                buffer_reg <= '0;
                                state_reg  <= IDLE;
                            end
`else
                            buffer_reg <= '0;
                            state_reg  <= IDLE;
`endif
                        end
                    end
                end
                default: state_reg <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_word_unstacker.sv
// Directed testbench for word_unstacker. Expected values are taken from hand-written word tables.
module tb_word_unstacker;
    logic clk_i = 1'b0;
    logic rst_ni;
    logic clr_i;
    logic enable_i;

    int total = 0;
    int bad   = 0;

    word_unstacker_if #(.WORD_W(32), .N_WORDS(4)) bus ();

    word_unstacker #(.WORD_W(32), .N_WORDS(4)) dut (
        .clk_i    (clk_i),
        .rst_ni   (rst_ni),
        .clr_i    (clr_i),
        .enable_i (enable_i),
        .bus      (bus)
    );

    always #5 clk_i = ~clk_i;

    logic [127:0] blk_a = 128'h00112233_44556677_8899AABB_CCDDEEFF;
    logic [127:0] blk_b = 128'hDEADBEEF_01234567_89ABCDEF_FEDCBA98;
    logic [31:0]  wa [4] = '{32'h00112233, 32'h44556677, 32'h8899AABB, 32'hCCDDEEFF};
    logic [31:0]  wb [4] = '{32'hDEADBEEF, 32'h01234567, 32'h89ABCDEF, 32'hFEDCBA98};

    // One line per completed output word transfer
    always @(posedge clk_i) begin
        if (rst_ni && bus.valid_o && bus.ready_i)
            $display("xfer word=%h last=%0d", bus.word_o, bus.last_o);
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got=timeout want=finish");
        $fatal(1);
    end

    task automatic step;
        @(posedge clk_i);
        #1;
    endtask

    // Present a block for one cycle; caller ensures the DUT is IDLE and enabled.
    task automatic send_block(input logic [127:0] b);
        bus.valid_i = 1'b1;
        bus.word_i  = b;
        step();
        bus.valid_i = 1'b0;
    endtask

    task automatic test_reset;
        rst_ni = 1'b0; clr_i = 1'b0; enable_i = 1'b1;
        bus.valid_i = 1'b0; bus.word_i = '0; bus.ready_i = 1'b0;
        #12;
        total++; if (bus.valid_o !== 1'b0) begin bad++; $display("FAIL reset_valid got=%b want=0", bus.valid_o); end
        total++; if (bus.word_o !== 32'h0) begin bad++; $display("FAIL reset_word got=%h want=0", bus.word_o); end
        total++; if (bus.last_o !== 1'b0) begin bad++; $display("FAIL reset_last got=%b want=0", bus.last_o); end
        total++; if (bus.ready_o !== 1'b1) begin bad++; $display("FAIL reset_ready got=%b want=1", bus.ready_o); end
        rst_ni = 1'b1;
        step();
    endtask

    task automatic test_single;
        bus.ready_i = 1'b1;
        total++; if (bus.ready_o !== 1'b1) begin bad++; $display("FAIL single_ready_idle got=%b want=1", bus.ready_o); end
        send_block(blk_a);
        for (int i = 0; i < 4; i++) begin
            total++; if (bus.valid_o !== 1'b1) begin bad++; $display("FAIL single_valid[%0d] got=%b want=1", i, bus.valid_o); end
            total++; if (bus.word_o !== wa[i]) begin bad++; $display("FAIL single_word[%0d] got=%h want=%h", i, bus.word_o, wa[i]); end
            total++; if (bus.last_o !== (i == 3)) begin bad++; $display("FAIL single_last[%0d] got=%b want=%b", i, bus.last_o, (i == 3)); end
            step();
        end
        total++; if (bus.valid_o !== 1'b0) begin bad++; $display("FAIL single_valid_end got=%b want=0", bus.valid_o); end
        total++; if (bus.ready_o !== 1'b1) begin bad++; $display("FAIL single_ready_end got=%b want=1", bus.ready_o); end
        total++; if (bus.word_o !== 32'h0) begin bad++; $display("FAIL single_word_end got=%h want=0", bus.word_o); end
    endtask

    task automatic test_backpressure;
        int k = 0;
        bus.ready_i = 1'b0;
        send_block(blk_a);
        for (int c = 0; c < 16 && k < 4; c++) begin
            bus.ready_i = ((c % 3) == 0);
            #1;
            total++; if (bus.valid_o !== 1'b1) begin bad++; $display("FAIL bp_valid[c%0d] got=%b want=1", c, bus.valid_o); end
            total++; if (bus.word_o !== wa[k]) begin bad++; $display("FAIL bp_word[c%0d] got=%h want=%h", c, bus.word_o, wa[k]); end
            total++; if (bus.last_o !== (k == 3)) begin bad++; $display("FAIL bp_last[c%0d] got=%b want=%b", c, bus.last_o, (k == 3)); end
            if (bus.ready_i) k++;
            step();
        end
        total++; if (k != 4) begin bad++; $display("FAIL bp_count got=%0d want=4", k); end
        total++; if (bus.valid_o !== 1'b0) begin bad++; $display("FAIL bp_valid_end got=%b want=0", bus.valid_o); end
    endtask

    task automatic test_back_to_back;
`ifdef UNSTACKER_PREFETCH_EN
        localparam int NC = 8;
`else
        localparam int NC = 9;
`endif
        logic        ev;
        logic [31:0] ew;
        logic        hs;
        bus.ready_i = 1'b1;
        bus.valid_i = 1'b1;
        bus.word_i  = blk_a;
        step();
        bus.word_i  = blk_b;
        for (int c = 0; c < NC; c++) begin
            ev = 1'b1;
`ifdef UNSTACKER_PREFETCH_EN
            ew = (c < 4) ? wa[c] : wb[c-4];
`else
            if (c < 4)       ew = wa[c];
            else if (c == 4) begin ev = 1'b0; ew = 32'h0; end
            else             ew = wb[c-5];
`endif
            total++; if (bus.valid_o !== ev) begin bad++; $display("FAIL b2b_valid[%0d] got=%b want=%b", c, bus.valid_o, ev); end
            total++; if (bus.word_o !== ew) begin bad++; $display("FAIL b2b_word[%0d] got=%h want=%h", c, bus.word_o, ew); end
            hs = bus.valid_i & bus.ready_o;
            step();
            if (hs) bus.valid_i = 1'b0;
        end
        bus.valid_i = 1'b0;
        total++; if (bus.valid_o !== 1'b0) begin bad++; $display("FAIL b2b_valid_end got=%b want=0", bus.valid_o); end
    endtask

    task automatic test_clear;
        bus.ready_i = 1'b1;
        send_block(blk_a);
        total++; if (bus.word_o !== wa[0]) begin bad++; $display("FAIL clr_w0 got=%h want=%h", bus.word_o, wa[0]); end
        step();
        total++; if (bus.word_o !== wa[1]) begin bad++; $display("FAIL clr_w1 got=%h want=%h", bus.word_o, wa[1]); end
        step();
        clr_i = 1'b1;
        step();
        clr_i = 1'b0;
        total++; if (bus.valid_o !== 1'b0) begin bad++; $display("FAIL clr_valid got=%b want=0", bus.valid_o); end
        total++; if (bus.ready_o !== 1'b1) begin bad++; $display("FAIL clr_ready got=%b want=1", bus.ready_o); end
        total++; if (bus.word_o !== 32'h0) begin bad++; $display("FAIL clr_word got=%h want=0", bus.word_o); end
        send_block(blk_b);
        for (int i = 0; i < 4; i++) begin
            total++; if (bus.word_o !== wb[i]) begin bad++; $display("FAIL clr_new_word[%0d] got=%h want=%h", i, bus.word_o, wb[i]); end
            total++; if (bus.last_o !== (i == 3)) begin bad++; $display("FAIL clr_new_last[%0d] got=%b want=%b", i, bus.last_o, (i == 3)); end
            step();
        end
    endtask

    task automatic test_enable;
        bus.ready_i = 1'b1;
        send_block(blk_a);
        total++; if (bus.word_o !== wa[0]) begin bad++; $display("FAIL en_w0 got=%h want=%h", bus.word_o, wa[0]); end
        step();
        enable_i = 1'b0;
        #1;
        for (int c = 0; c < 3; c++) begin
            total++; if (bus.valid_o !== 1'b0) begin bad++; $display("FAIL en_valid[%0d] got=%b want=0", c, bus.valid_o); end
            total++; if (bus.ready_o !== 1'b0) begin bad++; $display("FAIL en_ready[%0d] got=%b want=0", c, bus.ready_o); end
            total++; if (bus.word_o !== wa[1]) begin bad++; $display("FAIL en_word[%0d] got=%h want=%h", c, bus.word_o, wa[1]); end
            step();
        end
        enable_i = 1'b1;
        #1;
        for (int i = 1; i < 4; i++) begin
            total++; if (bus.valid_o !== 1'b1) begin bad++; $display("FAIL en_resume_valid[%0d] got=%b want=1", i, bus.valid_o); end
            total++; if (bus.word_o !== wa[i]) begin bad++; $display("FAIL en_resume_word[%0d] got=%h want=%h", i, bus.word_o, wa[i]); end
            step();
        end
        total++; if (bus.valid_o !== 1'b0) begin bad++; $display("FAIL en_valid_end got=%b want=0", bus.valid_o); end
    endtask

    task automatic test_async_reset;
        bus.ready_i = 1'b1;
        send_block(blk_a);
        step(); step(); step();
        bus.ready_i = 1'b0;
        #1;
        total++; if (bus.last_o !== 1'b1) begin bad++; $display("FAIL ar_last_pre got=%b want=1", bus.last_o); end
        #2;
        rst_ni = 1'b0;
        #1;
        total++; if (bus.valid_o !== 1'b0) begin bad++; $display("FAIL ar_valid got=%b want=0", bus.valid_o); end
        total++; if (bus.last_o !== 1'b0) begin bad++; $display("FAIL ar_last got=%b want=0", bus.last_o); end
        total++; if (bus.word_o !== 32'h0) begin bad++; $display("FAIL ar_word got=%h want=0", bus.word_o); end
        enable_i = 1'b0;
        #1;
        total++; if (bus.ready_o !== 1'b0) begin bad++; $display("FAIL ar_ready_dis got=%b want=0", bus.ready_o); end
        enable_i = 1'b1;
        #1;
        rst_ni = 1'b1;
        step();
        total++; if (bus.valid_o !== 1'b0) begin bad++; $display("FAIL ar_valid_after got=%b want=0", bus.valid_o); end
        total++; if (bus.ready_o !== 1'b1) begin bad++; $display("FAIL ar_ready_after got=%b want=1", bus.ready_o); end
    endtask

    initial begin
        test_reset();
        test_single();
        test_backpressure();
        test_back_to_back();
        test_clear();
        test_enable();
        test_async_reset();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
